life_game_stepper: RTL
======================

// Module: life_game_stepper
// PURPOSE
//  Generation-tick generator for the life game engine. Replaces the chained clock dividers and the 4:1 clock mux with one
//  single-clock block that emits one-cycle enable pulses. Adds selectable rate, run/pause, single-step, clear, a
//  generation counter and a busy handshake with overrun flagging. The engine runs on the system clock and is gated by step_tick.
// PARAMETERS
//  PRESCALE_CYCLES  12_500_000  system clocks per base period (125 ms at 100 MHz); must be >= 2
//  RATE_COUNT       4           number of rates; rate k period = base period * 2^k
//  RATE_WIDTH       2           width of rate_select; 2^RATE_WIDTH >= RATE_COUNT
//  GEN_WIDTH        16          generation counter width
// PORTS
//  clock         in   1           system clock; all logic on posedge
//  reset         in   1           synchronous, active-high
//  run           in   1           1 = free-running ticks, 0 = paused
//  step_request  in   1           debounced button level; rising edge requests one tick while paused
//  rate_select   in   RATE_WIDTH  rate index; values >= RATE_COUNT clamp to RATE_COUNT-1
//  clear         in   1           level; while high the generation is held at 0 and ticks are suppressed
//  engine_busy   in   1           engine still computing the previous generation
//  step_tick     out  1           one-cycle pulse: advance the engine one generation
//  clear_tick    out  1           one-cycle pulse on the rising edge of clear
//  generation    out  GEN_WIDTH   count of issued step_ticks since reset/clear; wraps modulo 2^GEN_WIDTH
//  overrun       out  1           sticky: a tick arrived while one was already pending
//  base_tick     out  1           one-cycle pulse every PRESCALE_CYCLES (LED heartbeat)
// BEHAVIOUR
//  - Reset: all outputs 0, prescaler 0, rate counter 0, pending 0, edge registers 0. Reset mid-operation abandons everything.
//  - Prescaler: counts 0..PRESCALE_CYCLES-1, runs in all modes. base_tick=1 in the cycle the count wraps to 0.
//  - Rate counter: on base_tick, if count == 2^sel-1 -> raw tick, count<=0; else count++. sel is the clamped rate_select.
//    Change in rate_select (registered compare) -> rate counter <= 0 that cycle; no raw tick that cycle.
//  - Raw tick sources: run=1 -> rate-counter tick; run=0 -> rising edge of step_request (previous level registered).
//    Rate counter keeps running while paused, but its ticks are discarded. step_request edges are ignored while run=1.
//  - Issue: pending or raw tick, and engine_busy=0 -> step_tick=1 next cycle (1-cycle latency), pending<=0, generation++.
//    Raw tick with engine_busy=1 -> pending<=1 (one slot). Raw tick while pending=1 -> coalesced; overrun<=1.
//    step_tick is never high in two consecutive cycles. The engine must raise busy in the cycle after step_tick,
//    or the next tick may issue.
//  - Clear: rising edge -> clear_tick=1 next cycle. While clear=1: generation<=0, pending<=0, step_tick=0, overrun<=0,
//    rate counter<=0. Clear beats a simultaneous raw tick or issue.
//  - Wrap: generation 2^GEN_WIDTH-1 + tick -> 0. overrun is cleared only by reset or clear.
//  - run falling while a tick is pending: the pending tick still issues once busy drops.
// TESTING (PRESCALE_CYCLES=4, RATE_COUNT=4, GEN_WIDTH=4)
//  1 reset, run=1, sel=0, busy=0 -> base_tick every 4 clocks; step_tick 1 clock after each; generation 1,2,3...
//  2 sel=2 -> step_tick every 16 clocks; switch to sel=1 mid-period -> first tick 8 clocks after the change;
//    sel=3'b111 (RATE_WIDTH=3 variant) behaves as sel=3 (32 clocks)
//  3 run=0, three step_request pulses spaced 10 clocks -> exactly 3 step_ticks, generation=3;
//    held-high step_request -> one tick only
//  4 busy=1 over 2 raw ticks -> no step_tick, overrun=1; busy drops -> one step_tick next cycle, generation+1
//  5 clear pulse coincident with a raw tick -> clear_tick=1, no step_tick, generation=0, overrun=0; 16 ticks wrap 15->0
//  6 reset asserted while pending=1 -> all outputs 0 next cycle, no step_tick after release until next period

Source files
------------

// File: rtl/life_game_stepper.sv
// Generation-tick generator: single-clock prescaler, selectable rate, run/pause/single-step,
// clear, generation counter and a one-slot pending tick with sticky overrun flag.
module life_game_stepper #(
   parameter int PRESCALE_CYCLES = 12_500_000,
   parameter int RATE_COUNT      = 4,
   parameter int RATE_WIDTH      = 2,
   parameter int GEN_WIDTH       = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  step_request,
   input  logic [RATE_WIDTH-1:0] rate_select,
   input  logic                  clear,
   input  logic                  engine_busy,
   output logic                  step_tick,
   output logic                  clear_tick,
   output logic [GEN_WIDTH-1:0]  generation,
   output logic                  overrun,
   output logic                  base_tick
);

   localparam int PRE_W = $clog2(PRESCALE_CYCLES);
   localparam int RC_W  = (RATE_COUNT > 1) ? RATE_COUNT - 1 : 1;
   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PRESCALE_CYCLES - 1);
   localparam logic [RATE_WIDTH-1:0] SEL_MAX  = RATE_WIDTH'(RATE_COUNT - 1);

   function automatic logic [RATE_WIDTH-1:0] clamp_sel(input logic [RATE_WIDTH-1:0] s);
      return (s > SEL_MAX) ? SEL_MAX : s;
   endfunction

   // Terminal count of the rate counter: 2^sel - 1 base periods.
   function automatic logic [RC_W-1:0] rate_limit(input logic [RATE_WIDTH-1:0] s);
      logic [RC_W:0] one_hot;
      one_hot = (RC_W + 1)'(1) << s;
      return RC_W'(one_hot - (RC_W + 1)'(1));
   endfunction

   logic [PRE_W-1:0]      pre_cnt;
   logic [RC_W-1:0]       rate_cnt;
   logic [RC_W-1:0]       limit;
   logic [RATE_WIDTH-1:0] rate_select_p1;
   logic                  step_request_p1;
   logic                  clear_p1;
   logic                  pending;

   logic rate_changed;
   logic rate_hit;
   logic step_edge;
   logic raw_tick;
   logic issue;

   // Stage 0: raw tick sources and issue decision from registered state
   always_comb begin
      limit        = rate_limit(clamp_sel(rate_select));
      rate_changed = (rate_select != rate_select_p1);
      rate_hit     = base_tick && !rate_changed && (rate_cnt >= limit);
      step_edge    = step_request && !step_request_p1;
      raw_tick     = run ? rate_hit : step_edge;
      issue        = (pending || raw_tick) && !engine_busy && !step_tick;
   end

   // Stage 1: registered outputs and counters
   always_ff @(posedge clock) begin
      if (reset) begin
         pre_cnt         <= '0;
         rate_cnt        <= '0;
         rate_select_p1  <= '0;
         step_request_p1 <= 1'b0;
         clear_p1        <= 1'b0;
         pending         <= 1'b0;
         step_tick       <= 1'b0;
         clear_tick      <= 1'b0;
         generation      <= '0;
         overrun         <= 1'b0;
         base_tick       <= 1'b0;
      end else begin
         rate_select_p1  <= rate_select;
         step_request_p1 <= step_request;
         clear_p1        <= clear;
         clear_tick      <= clear && !clear_p1;

         if (pre_cnt == PRE_LAST) begin
            pre_cnt   <= '0;
            base_tick <= 1'b1;
         end else begin
            pre_cnt   <= pre_cnt + 1'b1;
            base_tick <= 1'b0;
         end

         if (clear || rate_changed) begin
            rate_cnt <= '0;
         end else if (base_tick) begin
            rate_cnt <= (rate_cnt >= limit) ? '0 : rate_cnt + 1'b1;
         end

         // Clear overrides any tick arriving or issuing in the same cycle.
         if (clear) begin
            step_tick  <= 1'b0;
            pending    <= 1'b0;
            generation <= '0;
            overrun    <= 1'b0;
         end else begin
            step_tick <= issue;
            if (issue) begin
               generation <= generation + 1'b1;
               pending    <= 1'b0;
            end else if (raw_tick) begin
               pending    <= 1'b1;
            end
            if (raw_tick && pending) begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule
